bin_to_hex_display: RTL
=======================

# bin_to_hex_display

Parametrised multi-digit seven-segment display driver for the DE-series HEX displays. It accepts an unsigned binary value through a load/busy/done handshake. A sequential shift-add-3 (double-dabble) engine converts the value to BCD, and the driver then drives DIGITS active-low seven-segment outputs. Optional features are leading-zero blanking, overflow indication and blinking. It sits between switch/counter logic and the HEX pins, replacing per-digit hand-wired decoders.

## Interface
- DIGITS, 4: number of HEX digits driven (1..8).
- WIDTH, 14: width of the binary input value.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period (0.5 s at 50 MHz).
- CLOCK_50  in  1  system clock; the block uses only this clock.
- reset  in  1  synchronous, active-high reset.
- value  in  WIDTH  unsigned binary value; sampled only when a load is accepted.
- load  in  1  conversion request; accepted only in IDLE.
- blank_lz  in  1  1 = blank leading zeros; digit 0 is never blanked.
- blink  in  1  1 = blank the whole display on alternate blink phases.
- busy  out  1  high while a conversion is in progress (CONVERT or COMMIT).
- done  out  1  one-cycle pulse when new digits are committed.
- HEX  out  7*DIGITS  active-low segments.
  - Digit k occupies HEX[7k+6:7k]; bit 7k+6 = a … bit 7k = g.
  - Digit 0 is the least-significant digit.

## Operation
- Segment patterns (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - blank=1111111, dash=1111110
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE & load: capture value into shift register; clear BCD register (DIGITS nibbles) and step counter; latch ovf = (value ≥ 10^DIGITS); go to CONVERT.
  - CONVERT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, shift} left by one; increment counter. After WIDTH steps, go to COMMIT.
  - COMMIT: copy BCD into display digit registers; copy ovf; set valid=1; done=1; go to IDLE.
- load is ignored in CONVERT and COMMIT; it is not queued.
- Display priority, applied combinationally to registered state:
  1. Blink-off: blink=1 and phase=1 → all digits blank.
  2. Not yet valid: valid=0 → all digits blank.
  3. Overflow: ovf=1 → all digits dash.
  4. Leading-zero blank: digit k>0 is blank if blank_lz=1 and all digits k..DIGITS-1 are 0.
  5. Otherwise: decoded digit; BCD 10..15 cannot occur but decode to blank.
- Blink timer: free-running counter 0..BLINK_DIV-1. On wrap, phase toggles. The timer runs regardless of the blink input.
- Mid-operation changes:
  - blank_lz and blink take effect on the next combinational evaluation, with no conversion needed.
  - value changes after capture have no effect on the current conversion.

## Timing
- Reset values:
  - state IDLE; busy=0; done=0
  - valid=0, so HEX is all ones
  - digit registers 0; ovf=0; blink counter 0; phase 0
- Load sampled at edge 0: busy=1 from edge 0 to edge WIDTH+1; done=1 and HEX updated in the cycle after edge WIDTH+1.
  - Latency from load to new display: WIDTH+2 edges.
- The next load is accepted at the first IDLE edge after done.
- Reset asserted mid-conversion: the conversion is abandoned with no done pulse; outputs return to their reset values on the next edge.
- Simultaneous reset and load: reset wins.
- HEX is combinational from registers only; there is no combinational path from the value or load inputs.

## Structure
- Package hex_display_pkg holds:
  - SEG_BLANK and SEG_DASH constants
  - the 10-entry digit-pattern constant table
  - the state enum typedef
- Sub-module hex_digit_encoder: combinational; inputs 4-bit digit, blank and dash; output 7-bit active-low pattern. It is instantiated DIGITS times via generate.
- The top level holds the FSM, the double-dabble datapath, the blink timer and the blanking logic.

## Test plan
- **Reset:** assert reset for 2 cycles → HEX all ones, busy=0, done=0.
- **Basic conversion:** value=1234, load pulse → busy high for 15 cycles, then a single done pulse. Digits 3..0 show 1001111, 0010010, 0000110, 1001100.
- **Leading-zero blanking:** value=7, blank_lz=1 → digits 3..1 = 1111111, digit 0 = 0001111. Toggle blank_lz=0 → digits 3..1 = 0000001 in the same cycle.
- **Overflow:** value=10000 → all digits 1111110. Then value=0 → digit 0 = 0000001; digits 3..1 blank when blank_lz=1.
- **Handshake and reset:**
  - load 42 during a conversion of 9999 → ignored; the display shows 9999.
  - reset at step 5 of a conversion → no done pulse; HEX all ones.
- **Blink:** BLINK_DIV=4, blink=1, value=55 shown → HEX alternates between blank and 55 every 4 cycles. blink=0 → steady display.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared constants and types for the binary-to-HEX display driver.
// Segment patterns are active-low, ordered a..g from MSB to LSB.
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    // Entry n is the pattern for decimal digit n.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
        7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_hex_display_if.sv
// Load/busy/done handshake, display controls and segment outputs of the HEX driver.
interface bin_to_hex_display_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned WIDTH  = 14
);
    logic [WIDTH-1:0]    value;
    logic                load;
    logic                blank_lz;
    logic                blink;
    logic                busy;
    logic                done;
    logic [7*DIGITS-1:0] HEX;

    modport master (
        output value, load, blank_lz, blink,
        input  busy, done, HEX
    );

    modport slave (
        input  value, load, blank_lz, blink,
        output busy, done, HEX
    );
endinterface

// File: rtl/hex_digit_encoder.sv
// One seven-segment digit: blank overrides dash, dash overrides the BCD value.
module hex_digit_encoder
    import hex_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (blank) begin
            seg = SEG_BLANK;
        end else if (dash) begin
            seg = SEG_DASH;
        end else if (digit <= 4'd9) begin
            seg = SEG_TABLE[digit];
        end
    end

endmodule

// File: rtl/bin_to_hex_display.sv
// Multi-digit HEX driver: sequential double-dabble conversion, then
// blanking/overflow/blink applied combinationally to the committed digits.
module bin_to_hex_display
    import hex_display_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned WIDTH     = 14,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    bin_to_hex_display_if.slave  bus
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   step_q, step_d;
    logic               conv_ovf_q, conv_ovf_d;
    logic [BCD_W-1:0]   digits_q, digits_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_adj;

    logic [BLK_W-1:0]   blink_cnt_q;
    logic               phase_q;

    // Next-state and datapath for the load -> convert -> commit sequence.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_d      = bcd_q;
        step_d     = step_q;
        conv_ovf_d = conv_ovf_q;
        digits_d   = digits_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        done_d     = 1'b0;
        bcd_adj    = bcd_q;

        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    shift_d    = bus.value;
                    bcd_d      = '0;
                    step_d     = '0;
                    conv_ovf_d = (64'(bus.value) >= OVF_LIMIT);
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
                step_d = step_q + CNT_W'(1);
                if (step_q == CNT_W'(WIDTH - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                digits_d = bcd_q;
                ovf_d    = conv_ovf_q;
                valid_d  = 1'b1;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bcd_q      <= '0;
            step_q     <= '0;
            conv_ovf_q <= 1'b0;
            digits_q   <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_q      <= bcd_d;
            step_q     <= step_d;
            conv_ovf_q <= conv_ovf_d;
            digits_q   <= digits_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Free-running blink timer; phase flips every BLINK_DIV cycles.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + BLK_W'(1);
        end
    end

    logic [DIGITS-1:0] upper_zero;
    logic [DIGITS-1:0] dig_blank;
    logic              blank_all;
    logic              zero_run;

    // upper_zero[k]: digits k..DIGITS-1 are all zero.
    always_comb begin
        blank_all  = (bus.blink && phase_q) || !valid_q;
        zero_run   = 1'b1;
        upper_zero = '0;
        dig_blank  = '0;
        for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
            zero_run      = zero_run && (digits_q[4*k +: 4] == 4'd0);
            upper_zero[k] = zero_run;
            dig_blank[k]  = blank_all ||
                            ((k != 0) && bus.blank_lz && zero_run && !ovf_q);
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
        hex_digit_encoder u_enc (
            .digit (digits_q[4*g +: 4]),
            .blank (dig_blank[g]),
            .dash  (ovf_q),
            .seg   (bus.HEX[7*g +: 7])
        );
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
